// File: rtl/extmem_pkg.sv
// Shared definitions for the external memory port arbiter.
// Defaults here are also used by the bus interface unit.
package extmem_pkg;

    localparam int AW_DEF        = 32;
    localparam int DW_DEF        = 32;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    // Owner code presented on the status output for a given state
    function automatic logic [1:0] owner_of(input state_t s);
        logic [1:0] o;
        case (s)
            ST_OWN0: o = OWNER_M0;
            ST_OWN1: o = OWNER_M1;
            default: o = OWNER_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/extmem_arbiter_rr_pick2.sv
// Two-way round-robin choice: on a tie the side that was
// not served last wins; a single request always wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    // Pick the winner among the active requests
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/extmem_arbiter.sv
// Shares the single external memory data port between the CPU
// path (m0) and the display/copy engine (m1) with locked bursts.
module extmem_arbiter
    import extmem_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           m0_req,
    input  logic                           m0_lock,
    input  logic [AW-1:0]                  m0_addr,
    input  logic [DW-1:0]                  m0_wdata,
    input  logic [DW/8-1:0]                m0_we,
    output logic [DW-1:0]                  m0_rdata,
    output logic                           m0_ack,
    input  logic                           m1_req,
    input  logic                           m1_lock,
    input  logic [AW-1:0]                  m1_addr,
    input  logic [DW-1:0]                  m1_wdata,
    input  logic [DW/8-1:0]                m1_we,
    output logic [DW-1:0]                  m1_rdata,
    output logic                           m1_ack,
    output logic [AW-1:0]                  mem_addr,
    output logic [DW-1:0]                  mem_wdata,
    output logic [DW/8-1:0]                mem_we,
    input  logic [DW-1:0]                  mem_rdata,
    output logic [1:0]                     owner,
    output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic own_is1;
    logic cur_req;
    logic cur_lock;
    logic oth_req;
    logic pick_last;
    logic pick_win;
    logic pick_valid;

    // Current owner's view of both requesters; in OWNx the owner
    // itself is treated as "last" so a waiting peer wins the tie
    always_comb begin
        own_is1   = (state_q == ST_OWN1);
        cur_req   = own_is1 ? m1_req : m0_req;
        cur_lock  = own_is1 ? m1_lock : m0_lock;
        oth_req   = own_is1 ? m0_req : m1_req;
        pick_last = (state_q == ST_IDLE) ? last_q : own_is1;
    end

    rr_pick2 u_pick (
        .req0   (m0_req),
        .req1   (m1_req),
        .last   (pick_last),
        .winner (pick_win),
        .valid  (pick_valid)
    );

    // State, fairness history, burst count and held read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next owner: locked burst extension first, then round-robin
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = pick_win ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (cur_req && cur_lock && oth_req && (cnt_q < CNT_LIM)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (pick_valid) begin
                        state_d = pick_win ? ST_OWN1 : ST_OWN0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    if (!pick_valid || (pick_win != own_is1)) begin
                        last_d = own_is1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Memory-side mux and acks follow the registered owner
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        unique case (state_q)
            ST_OWN0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we    = m0_req ? m0_we : '0;
                m0_ack    = m0_req;
            end
            ST_OWN1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we    = m1_req ? m1_we : '0;
                m1_ack    = m1_req;
            end
            default: begin
            end
        endcase
        rdata0_d = m0_ack ? mem_rdata : rdata0_q;
        rdata1_d = m1_ack ? mem_rdata : rdata1_q;
        m0_rdata = rdata0_d;
        m1_rdata = rdata1_d;
        owner    = owner_of(state_q);
        beat_cnt = cnt_q;
    end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Directed bench for extmem_arbiter with a small word memory
// standing in for extern_mem.
module tb_extmem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_we;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_we;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic [1:0]  owner;
    logic [2:0]  beat_cnt;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] mem [0:255];

    extmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) mem[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
        m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       r0, l0, r1, l1;
        logic [1:0] own;
        logic       a0, a1;
        logic [2:0] bc;
    } vec_t;

    vec_t tbl [16];

    int i0, i1, last_ack, first_cyc, last_cyc;
    logic a0, a1;

    task automatic drive_stream();
        m0_req = (i0 < 8); m0_we = 4'hF;
        m0_addr = 32'h200 + 32'(i0 * 4); m0_wdata = 32'hA000_0000 | 32'(i0);
        m1_req = (i1 < 8); m1_we = 4'hF;
        m1_addr = 32'h300 + 32'(i1 * 4); m1_wdata = 32'hB000_0000 | 32'(i1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h040 >> 2] = 32'h11223344;
        mem[32'h080 >> 2] = 32'h55555555;

        // locked burst trace: r0 l0 r1 l1 | owner a0 a1 beat_cnt
        tbl[0]  = '{1,1,1,0, 2'b00,0,0,0};
        tbl[1]  = '{1,1,1,0, 2'b01,1,0,0};
        tbl[2]  = '{1,1,1,0, 2'b01,1,0,1};
        tbl[3]  = '{1,1,1,0, 2'b01,1,0,2};
        tbl[4]  = '{1,1,1,0, 2'b01,1,0,3};
        tbl[5]  = '{1,1,1,0, 2'b10,0,1,0};
        tbl[6]  = '{1,1,1,0, 2'b01,1,0,0};
        tbl[7]  = '{1,1,1,0, 2'b01,1,0,1};
        tbl[8]  = '{1,1,1,0, 2'b01,1,0,2};
        tbl[9]  = '{1,1,1,0, 2'b01,1,0,3};
        tbl[10] = '{1,1,1,0, 2'b10,0,1,0};
        tbl[11] = '{1,1,1,0, 2'b01,1,0,0};
        tbl[12] = '{1,0,1,0, 2'b01,1,0,1};
        tbl[13] = '{0,0,1,0, 2'b10,0,1,0};
        tbl[14] = '{0,0,0,0, 2'b10,0,0,0};
        tbl[15] = '{0,0,0,0, 2'b00,0,0,0};

        // reset state, with busy inputs to show they are ignored
        idle_inputs();
        reset = 1;
        m0_req = 1; m0_addr = 32'h100; m0_wdata = 32'hFFFF_FFFF; m0_we = 4'hF;
        @(negedge clk);
        check("rst_owner", owner, 2'b00);
        check("rst_beat", beat_cnt, 0);
        check("rst_ack0", m0_ack, 0);
        check("rst_ack1", m1_ack, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata0", m0_rdata, 0);
        check("rst_rdata1", m1_rdata, 0);

        // table: locked bursts capped at 4 beats
        do_reset();
        m0_addr = 32'h100; m1_addr = 32'h040;
        for (int i = 0; i < 16; i++) begin
            m0_req = tbl[i].r0; m0_lock = tbl[i].l0;
            m1_req = tbl[i].r1; m1_lock = tbl[i].l1;
            @(negedge clk);
            check($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
            check($sformatf("tbl%0d_ack0", i), m0_ack, tbl[i].a0);
            check($sformatf("tbl%0d_ack1", i), m1_ack, tbl[i].a1);
            check($sformatf("tbl%0d_beat", i), beat_cnt, tbl[i].bc);
            step();
        end

        // single reader
        do_reset();
        m0_req = 1; m0_addr = 32'h100;
        @(negedge clk);
        check("sr_idle_owner", owner, 2'b00);
        check("sr_idle_ack", m0_ack, 0);
        step();
        @(negedge clk);
        check("sr_owner", owner, 2'b01);
        check("sr_ack", m0_ack, 1);
        check("sr_rdata", m0_rdata, 32'hDEADBEEF);
        step();
        m0_req = 0;
        @(negedge clk);
        check("sr_noack", m0_ack, 0);
        check("sr_hold", m0_rdata, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("sr_back_idle", owner, 2'b00);

        // simultaneous first request out of reset
        do_reset();
        m0_req = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h040;
        @(negedge clk);
        check("sim_idle", owner, 2'b00);
        step();
        @(negedge clk);
        check("sim_own0", owner, 2'b01);
        check("sim_ack0", m0_ack, 1);
        check("sim_ack1_lo", m1_ack, 0);
        check("sim_rdata0", m0_rdata, 32'hDEADBEEF);
        step();
        m0_req = 0;
        @(negedge clk);
        check("sim_own1", owner, 2'b10);
        check("sim_ack1", m1_ack, 1);
        check("sim_rdata1", m1_rdata, 32'h11223344);
        step();
        m1_req = 0;
        step(); step();

        // unlocked contention: strict alternation, no gaps
        do_reset();
        i0 = 0; i1 = 0; last_ack = -1; first_cyc = -1; last_cyc = -1;
        drive_stream();
        for (int cyc = 0; cyc < 40 && !(i0 == 8 && i1 == 8); cyc++) begin
            @(negedge clk);
            a0 = m0_ack; a1 = m1_ack;
            if (a0 || a1) begin
                check($sformatf("alt_one_c%0d", cyc), a0 ^ a1, 1);
                if (last_ack >= 0) check($sformatf("alt_swap_c%0d", cyc), a1, last_ack == 0);
                last_ack = a1 ? 1 : 0;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            step();
            if (a0) i0++;
            if (a1) i1++;
            drive_stream();
        end
        check("alt_m0_beats", i0, 8);
        check("alt_m1_beats", i1, 8);
        check("alt_span", last_cyc - first_cyc + 1, 16);
        idle_inputs();
        step(); step();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("alt_mem0_%0d", k), mem[(32'h200 >> 2) + k], 32'hA000_0000 | 32'(k));
            check($sformatf("alt_mem1_%0d", k), mem[(32'h300 >> 2) + k], 32'hB000_0000 | 32'(k));
        end

        // byte write then read back on m1
        m1_req = 1; m1_addr = 32'h040; m1_we = 4'b0010; m1_wdata = 32'h0000AB00;
        step();
        @(negedge clk);
        check("bw_ack", m1_ack, 1);
        step();
        m1_we = 4'b0000; m1_wdata = 0;
        @(negedge clk);
        check("bw_rd_ack", m1_ack, 1);
        check("bw_rdata", m1_rdata, 32'h1122AB44);
        step();
        m1_req = 0;
        step(); step();

        // withdraw before ack: no write, no ack
        m0_req = 1; m0_addr = 32'h080; m0_we = 4'hF; m0_wdata = 32'hCAFEF00D;
        step();
        m0_req = 0;
        @(negedge clk);
        check("wd_owner", owner, 2'b01);
        check("wd_ack", m0_ack, 0);
        check("wd_we", mem_we, 0);
        step(); step();
        check("wd_mem", mem[32'h080 >> 2], 32'h55555555);
        check("wd_idle", owner, 2'b00);

        // reset asserted mid-burst acts without a clock
        do_reset();
        m1_req = 1; m1_addr = 32'h3F0; m1_we = 4'hF; m1_wdata = 32'h12345678;
        step();
        @(negedge clk);
        check("mr_owner1", owner, 2'b10);
        check("mr_we_on", mem_we, 4'hF);
        #2 reset = 1;
        #1;
        check("mr_owner0", owner, 2'b00);
        check("mr_we_off", mem_we, 0);
        check("mr_ack_off", m1_ack, 0);
        step();
        idle_inputs();
        m0_req = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h040;
        reset = 0;
        @(negedge clk);
        check("mr_post_idle", owner, 2'b00);
        step();
        @(negedge clk);
        check("mr_tie_owner", owner, 2'b01);
        check("mr_tie_ack0", m0_ack, 1);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/extmem_arbiter.md
Name: extmem_arbiter

Overview:
- Two-port arbiter sharing the single extern_mem data port between requester 0 (CPU path out of biu, port 3) and requester 1 (display refresh / copy engine).
- Round-robin arbitration with optional locked bursts capped at MAX_BURST beats.
- Sits between the biu port-3 interface and extern_mem, replacing their direct connection.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 wide)
- MAX_BURST, 4, maximum consecutive beats a locked owner keeps the port while the other requester waits (must be ≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  requester 0 transaction request, held until acked
- m0_lock  in  1  requester 0 wants to keep ownership for the next beat
- m0_addr  in  AW  requester 0 byte address
- m0_wdata  in  DW  requester 0 write data
- m0_we  in  DW/8  requester 0 byte write enables; 0 means read
- m0_rdata  out  DW  read data to requester 0
- m0_ack  out  1  beat-complete strobe to requester 0
- m1_req, m1_lock, m1_addr, m1_wdata, m1_we, m1_rdata, m1_ack  same as m0_*, for requester 1
- mem_addr  out  AW  to extern_mem daddr
- mem_wdata  out  DW  to extern_mem dwdata
- mem_we  out  DW/8  to extern_mem dwe
- mem_rdata  in  DW  from extern_mem drdata (combinational read)
- owner  out  2  00 idle, 01 m0, 10 m1
- beat_cnt  out  $clog2(MAX_BURST+1)  beats granted to current owner in the present contended run

Behaviour:
- Reset (async, reset=1): state IDLE, owner=00, beat_cnt=0, last=1 (so m0 wins the first tie); all acks 0; mem_we=0, mem_addr=0, mem_wdata=0; m*_rdata=0.
- States: IDLE, OWN0, OWN1. The state is registered; memory-side signals are a combinational mux of the owner's inputs.
- IDLE: mem_we forced 0. At a clock edge:
  - only one req high → go to that owner;
  - both high → go to the requester not equal to last;
  - none high → stay IDLE.
  - Latency from req rising to first ack: 1 cycle.
- OWNx:
  - mem_addr/wdata/we = mx_*; mx_ack = mx_req; mx_rdata = mem_rdata while ack; the other ack = 0.
  - A write commits at the clock edge ending the ack cycle.
  - If mx_req is low in OWNx (requester withdrew): mem_we forced 0, no ack.
- End of each OWNx cycle, in priority order:
  1. mx_req & mx_lock & other req & beat_cnt < MAX_BURST-1 → stay, beat_cnt+1.
  2. other req → switch to OWN(other) with no idle cycle; last=x; beat_cnt=0.
  3. mx_req (no contention) → stay, beat_cnt=0 (uncontended streaming is unlimited).
  4. else → IDLE, last=x, beat_cnt=0.
- Fairness: under continuous contention each requester gets at most MAX_BURST consecutive beats, then at least one beat passes to the other. Without lock, strict alternation.
- Requester protocol:
  - addr/we/wdata stable while req high and ack low.
  - After an ack the requester may present the next beat's fields and keep req high.
  - Dropping req without an ack abandons the request with no side effects.
- owner output mirrors state; beat_cnt saturates at MAX_BURST-1 and never wraps.
- Reset asserted mid-burst: returns immediately to IDLE and mem_we drops asynchronously. Any write whose commit edge coincides with reset assertion is not guaranteed.
- rdata for the non-owner is held at its last value; it is valid only with ack.

Decomposition:
- Shared package `extmem_pkg`:
  - state encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2;
  - owner codes;
  - default AW/DW/MAX_BURST constants, shared with biu.
- Sub-module `rr_pick2`: combinational 2-way round-robin choice (inputs req0, req1, last; output winner, valid). It is used by both the IDLE and OWNx transition logic.

Test Plan:
- Single reader: m0 reads 0x100 (mem holds 0xDEADBEEF), m1 idle → m0_ack one cycle after req, m0_rdata=0xDEADBEEF, owner=01, then IDLE after req drops.
- Simultaneous first request, both reads, out of reset → m0 granted first (last=1 at reset), then m1 on the next cycle with no idle gap; owners 01,10.
- Contention, no lock: both stream writes m0→0x200.., m1→0x300.. for 8 beats each → acks strictly alternate; 16 cycles total; memory shows all 16 words correct.
- Locked burst, MAX_BURST=4: m0 lock=1 for 10 beats while m1 req is held → m0 gets 4 beats (beat_cnt 0..3), m1 1 beat, m0 4, m1 1, m0 2; m1 never waits more than 4 cycles.
- Byte write: m1 we=4'b0010, wdata=0x0000AB00 to 0x40 holding 0x11223344 → reads back 0x1122AB44. Withdraw case: m0 req drops before ack → no write and no ack.
- Reset mid-burst: reset asserted during OWN1 with mem_we=4'hF → owner=00 and mem_we=0 immediately, without waiting for a clock; after release, m0/m1 tie goes to m0.
